moving_sum_decoder: RTL and testbench

Reconstructs the original sample stream x[n] from a full-precision moving-sum stream s[n] = SUM over k=0..N-1 of x[n-k], with window N = 2**WIND_WIDTH. It uses the recursion x[n] = s[n] - s[n-1] + x[n-N]. It sits at the receive end of the moving-average datapath, consuming the untruncated accumulator that the averaging filter produces before its shift. Past reconstructed samples are held in a small synchronous RAM addressed as a circular buffer.

---
 rtl/moving_avg_pkg.sv | 13 +
 rtl/moving_sum_dec_sdp_ram.sv | 30 +++
 rtl/moving_sum_decoder.sv | 117 +++++++++++
 tb/tb_moving_sum_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/moving_avg_pkg.sv
// Shared widths and helpers for the moving-average filter and its
// moving-sum decoder.
package moving_avg_pkg;

   localparam int DEFAULT_WIND_WIDTH = 4;
   localparam int DEFAULT_DATA_WIDTH = 16;

   // A sum of 2**wind_width samples needs wind_width extra bits to stay exact.
   function automatic int sum_width(input int wind_width, input int data_width);
      return data_width + wind_width;
   endfunction

endpackage

// File: rtl/moving_sum_dec_sdp_ram.sv
// Simple dual-port RAM holding the last N reconstructed samples.
// One write port and one registered read port; contents are not reset.
module moving_sum_dec_sdp_ram #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] dout
);

   (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
   logic [DATA_WIDTH-1:0] dout_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= din;
      end
      if (re) begin
         dout_q <= mem[raddr];
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/moving_sum_decoder.sv
// Recovers x[n] from a full-precision moving sum using
// x[n] = s[n] - s[n-1] + x[n-N], with past samples in a circular RAM.
module moving_sum_decoder
   import moving_avg_pkg::*;
#(
   parameter int WIND_WIDTH = DEFAULT_WIND_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   localparam int SUM_WIDTH = sum_width(WIND_WIDTH, DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [SUM_WIDTH-1:0]  s_N,
   input  logic                  s_N_valid,
   output logic [DATA_WIDTH-1:0] x_N,
   output logic                  x_N_valid,
   output logic                  window_full,
   output logic                  overflow
);

   localparam logic [WIND_WIDTH-1:0] ADDR_LAST = '1;

   logic [WIND_WIDTH-1:0] addr_q, addr_d;
   logic                  window_full_q, window_full_d;
   logic [SUM_WIDTH-1:0]  s_prev_q, s_prev_d;

   logic [SUM_WIDTH-1:0]  diff_q, diff_d;
   logic [WIND_WIDTH-1:0] addr_s1_q, addr_s1_d;
   logic                  wf_at_accept_q, wf_at_accept_d;
   logic                  v1_q, v1_d;

   logic [DATA_WIDTH-1:0] x_q, x_d;
   logic                  x_valid_q, x_valid_d;
   logic                  overflow_q, overflow_d;

   logic [DATA_WIDTH-1:0] ram_dout;
   logic [SUM_WIDTH-1:0]  history;
   logic [SUM_WIDTH-1:0]  x_full;

   moving_sum_dec_sdp_ram #(
      .ADDR_WIDTH (WIND_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (v1_q),
      .waddr (addr_s1_q),
      .din   (x_full[DATA_WIDTH-1:0]),
      .re    (s_N_valid),
      .raddr (addr_q),
      .dout  (ram_dout)
   );

   // Until the window has filled, the RAM slot holds stale data and the
   // sample leaving the window is by definition zero.
   assign history = wf_at_accept_q ? {{WIND_WIDTH{1'b0}}, ram_dout} : '0;
   assign x_full  = diff_q + history;

   always_comb begin
      addr_d         = addr_q;
      window_full_d  = window_full_q;
      s_prev_d       = s_prev_q;
      diff_d         = diff_q;
      addr_s1_d      = addr_s1_q;
      wf_at_accept_d = wf_at_accept_q;
      v1_d           = s_N_valid;
      x_d            = x_q;
      x_valid_d      = v1_q;
      overflow_d     = overflow_q;

      if (s_N_valid) begin
         diff_d         = s_N - s_prev_q;
         s_prev_d       = s_N;
         addr_s1_d      = addr_q;
         wf_at_accept_d = window_full_q;
         addr_d         = addr_q + WIND_WIDTH'(1);
         if (addr_q == ADDR_LAST) begin
            window_full_d = 1'b1;
         end
      end

      if (v1_q) begin
         x_d        = x_full[DATA_WIDTH-1:0];
         overflow_d = overflow_q | (|x_full[SUM_WIDTH-1:DATA_WIDTH]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q         <= '0;
         window_full_q  <= 1'b0;
         s_prev_q       <= '0;
         diff_q         <= '0;
         addr_s1_q      <= '0;
         wf_at_accept_q <= 1'b0;
         v1_q           <= 1'b0;
         x_q            <= '0;
         x_valid_q      <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         addr_q         <= addr_d;
         window_full_q  <= window_full_d;
         s_prev_q       <= s_prev_d;
         diff_q         <= diff_d;
         addr_s1_q      <= addr_s1_d;
         wf_at_accept_q <= wf_at_accept_d;
         v1_q           <= v1_d;
         x_q            <= x_d;
         x_valid_q      <= x_valid_d;
         overflow_q     <= overflow_d;
      end
   end

   assign x_N         = x_q;
   assign x_N_valid   = x_valid_q;
   assign window_full = window_full_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_moving_sum_decoder.sv
// Directed and randomised checks of moving_sum_decoder: an N=4, 8-bit
// instance for table-driven corner cases and an N=2 instance for a random stream.
module tb_moving_sum_decoder;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   // Instance A: WIND_WIDTH=2, DATA_WIDTH=8 (SUM_WIDTH=10)
   logic [9:0] s_a = '0;
   logic       valid_a = 1'b0;
   logic [7:0] x_a;
   logic       xv_a, wf_a, ovf_a;

   // Instance B: WIND_WIDTH=1, DATA_WIDTH=8 (SUM_WIDTH=9)
   logic [8:0] s_b = '0;
   logic       valid_b = 1'b0;
   logic [7:0] x_b;
   logic       xv_b, wf_b, ovf_b;

   moving_sum_decoder #(.WIND_WIDTH(2), .DATA_WIDTH(8)) dut_a (
      .clk         (clk),
      .reset       (reset),
      .s_N         (s_a),
      .s_N_valid   (valid_a),
      .x_N         (x_a),
      .x_N_valid   (xv_a),
      .window_full (wf_a),
      .overflow    (ovf_a)
   );

   moving_sum_decoder #(.WIND_WIDTH(1), .DATA_WIDTH(8)) dut_b (
      .clk         (clk),
      .reset       (reset),
      .s_N         (s_b),
      .s_N_valid   (valid_b),
      .x_N         (x_b),
      .x_N_valid   (xv_b),
      .window_full (wf_b),
      .overflow    (ovf_b)
   );

   typedef struct {
      logic [9:0] s;
      logic [7:0] x;
      logic       wf;
      logic       ovf;
   } vec_t;

   vec_t tbl[$];
   int   tests_run = 0;
   int   tests_failed = 0;

   logic [7:0] ref_q[$];
   logic [7:0] prev_x;
   logic [7:0] new_x;
   logic [7:0] exp_x;
   int         sent;
   int         cycles;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [9:0] s, input logic v);
      s_a     = s;
      valid_a = v;
   endtask

   task automatic pushVec(input logic [9:0] s, input logic [7:0] x, input logic wf, input logic ovf);
      vec_t v;
      v.s   = s;
      v.x   = x;
      v.wf  = wf;
      v.ovf = ovf;
      tbl.push_back(v);
   endtask

   // Back-to-back stream: vector i is driven at negedge i and its result is
   // visible two negedges later.
   task automatic runTable(input string tag);
      int n;
      n = tbl.size();
      for (int i = 0; i < n + 2; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            checkOutput($sformatf("%s[%0d] x_N_valid", tag, i - 2), xv_a, 1);
            checkOutput($sformatf("%s[%0d] x_N", tag, i - 2), x_a, tbl[i-2].x);
            checkOutput($sformatf("%s[%0d] window_full", tag, i - 2), wf_a, tbl[i-2].wf);
            checkOutput($sformatf("%s[%0d] overflow", tag, i - 2), ovf_a, tbl[i-2].ovf);
         end
         if (i < n) applyStimulus(tbl[i].s, 1'b1);
         else       applyStimulus('0, 1'b0);
      end
      @(negedge clk);
      checkOutput($sformatf("%s trailing x_N_valid", tag), xv_a, 0);
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      applyStimulus('0, 1'b0);
      valid_b = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [9:0] gap_s [6];
      gap_s = '{10'd1, 10'd3, 10'd6, 10'd10, 10'd14, 10'd18};

      repeat (2) @(negedge clk);
      checkOutput("reset x_N", x_a, 0);
      checkOutput("reset x_N_valid", xv_a, 0);
      checkOutput("reset window_full", wf_a, 0);
      checkOutput("reset overflow", ovf_a, 0);
      reset = 1'b0;

      // s = 1,3,6,10,14,18 -> x = 1..6; window_full visible once 4 accepted
      tbl.delete();
      pushVec(10'd1,  8'd1, 1'b0, 1'b0);
      pushVec(10'd3,  8'd2, 1'b0, 1'b0);
      pushVec(10'd6,  8'd3, 1'b1, 1'b0);
      pushVec(10'd10, 8'd4, 1'b1, 1'b0);
      pushVec(10'd14, 8'd5, 1'b1, 1'b0);
      pushVec(10'd18, 8'd6, 1'b1, 1'b0);
      runTable("b2b");

      // Same stream with 3 idle cycles after each input
      doReset();
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         applyStimulus(gap_s[j], 1'b1);
         @(negedge clk);
         applyStimulus('0, 1'b0);
         checkOutput($sformatf("gap[%0d] early x_N_valid", j), xv_a, 0);
         @(negedge clk);
         checkOutput($sformatf("gap[%0d] x_N_valid", j), xv_a, 1);
         checkOutput($sformatf("gap[%0d] x_N", j), x_a, j + 1);
         @(negedge clk);
         checkOutput($sformatf("gap[%0d] idle x_N_valid", j), xv_a, 0);
         checkOutput($sformatf("gap[%0d] held x_N", j), x_a, j + 1);
      end
      checkOutput("gap window_full", wf_a, 1);

      // Modular wrap and inconsistent sum. s=1023 after 765 gives
      // diff=258 plus x[n-4]=255 -> 513, so x_N=1 and overflow sets.
      doReset();
      tbl.delete();
      pushVec(10'd255,  8'd255, 1'b0, 1'b0);
      pushVec(10'd510,  8'd255, 1'b0, 1'b0);
      pushVec(10'd765,  8'd255, 1'b1, 1'b0);
      pushVec(10'd1020, 8'd255, 1'b1, 1'b0);
      pushVec(10'd1020, 8'd255, 1'b1, 1'b0);
      pushVec(10'd765,  8'd0,   1'b1, 1'b0);
      pushVec(10'd1023, 8'd1,   1'b1, 1'b1);
      pushVec(10'd1023, 8'd255, 1'b1, 1'b1);
      runTable("wrap");
      repeat (3) @(negedge clk);
      checkOutput("sticky overflow", ovf_a, 1);

      // Asynchronous reset with one sample in stage 1 and one in stage 2
      @(negedge clk);
      applyStimulus(10'd100, 1'b1);
      @(negedge clk);
      applyStimulus(10'd200, 1'b1);
      @(posedge clk);
      #2;
      checkOutput("pre-reset x_N_valid", xv_a, 1);
      reset = 1'b1;
      #1;
      checkOutput("async reset x_N_valid", xv_a, 0);
      checkOutput("async reset x_N", x_a, 0);
      checkOutput("async reset window_full", wf_a, 0);
      checkOutput("async reset overflow", ovf_a, 0);
      @(negedge clk);
      applyStimulus('0, 1'b0);
      reset = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checkOutput("dropped sample x_N_valid", xv_a, 0);
      end
      tbl.delete();
      pushVec(10'd7, 8'd7, 1'b0, 1'b0);
      pushVec(10'd7, 8'd0, 1'b0, 1'b0);
      runTable("restart");

      // N=2 instance: random samples through a reference moving sum
      doReset();
      prev_x = '0;
      sent   = 0;
      cycles = 0;
      ref_q.delete();
      while ((sent < 1000 || ref_q.size() > 0) && cycles < 5000) begin
         @(negedge clk);
         cycles++;
         if (xv_b) begin
            if (ref_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL rand spurious pulse: got x_N=%0d, expected no pulse", x_b);
            end else begin
               exp_x = ref_q.pop_front();
               checkOutput("rand x_N", x_b, exp_x);
            end
         end
         if (sent < 1000 && $urandom_range(0, 99) < 60) begin
            new_x   = 8'($urandom_range(0, 255));
            s_b     = {1'b0, new_x} + {1'b0, prev_x};
            valid_b = 1'b1;
            ref_q.push_back(new_x);
            prev_x  = new_x;
            sent++;
         end else begin
            valid_b = 1'b0;
         end
      end
      valid_b = 1'b0;
      checkOutput("rand samples sent", sent, 1000);
      checkOutput("rand outstanding", ref_q.size(), 0);
      checkOutput("rand overflow", ovf_b, 0);
      checkOutput("rand window_full", wf_b, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
